// File: rtl/decoder_iter_ctrl_pkg.sv
// Shared definitions for the min-sum decoder iteration controller.
//   state_t   : controller FSM encoding
//   RESET_VAL : value every control output/flag takes in reset
package decoder_iter_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic RESET_VAL = 1'b0;

endpackage

// File: rtl/decoder_iter_ctrl_if.sv
// Handshake bundle between the iteration controller (master) and its
// environment: LLR assembler, min-sum datapath and result consumer (slave).
//   llr_ready/llr_ack      : codeword handoff from the assembler
//   load_en                : datapath latches the LLR vector
//   layer_start/layer_done : one iteration request/completion
//   syndrome_ok            : hard decision satisfies all checks
//   out_valid/out_ready    : result handoff with iters_used/early_stop/timeout_err
//   busy                   : controller not idle
interface decoder_iter_ctrl_if #(
  parameter int ITER_W = 4
);
  logic              llr_ready;
  logic              llr_ack;
  logic              load_en;
  logic              layer_start;
  logic              layer_done;
  logic              syndrome_ok;
  logic              out_valid;
  logic              out_ready;
  logic [ITER_W-1:0] iters_used;
  logic              early_stop;
  logic              timeout_err;
  logic              busy;

  modport master (
    input  llr_ready, layer_done, syndrome_ok, out_ready,
    output llr_ack, load_en, layer_start, out_valid,
           iters_used, early_stop, timeout_err, busy
  );

  modport slave (
    output llr_ready, layer_done, syndrome_ok, out_ready,
    input  llr_ack, load_en, layer_start, out_valid,
           iters_used, early_stop, timeout_err, busy
  );
endinterface

// File: rtl/decoder_iter_ctrl_watchdog.sv
// Per-layer watchdog counter.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force count to 0
//   enable   : count one cycle
//   count    : cycles counted since the last clear (saturates at TIMEOUT)
//   expired  : this enabled cycle brings the count to TIMEOUT
module decoder_watchdog #(
  parameter int TMO_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [TMO_W-1:0] count,
  output logic             expired
);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (enable && count != TMO_MAX)
      count <= count + 1'b1;
  end

  // Flags the cycle whose increment reaches TIMEOUT, so a layer gets
  // exactly TIMEOUT cycles in WAIT before the abort.
  assign expired = enable && (count == TMO_LAST);

endmodule

// File: rtl/decoder_iter_ctrl.sv
// Iteration controller for a min-sum LDPC decoder. Accepts a codeword from
// the LLR assembler, runs up to N_ITER datapath iterations, stops early on a
// satisfied syndrome or aborts on a per-layer watchdog, then presents the
// result until the consumer accepts it. All outputs are registered.
//   clk, rst : clock, synchronous active-high reset
//   bus      : decoder_iter_ctrl_if master modport (see interface header)
module decoder_iter_ctrl
  import decoder_iter_ctrl_pkg::*;
#(
  parameter int N_ITER  = 5,
  parameter int ITER_W  = 4,
  parameter int TIMEOUT = 255,
  parameter int TMO_W   = 8
) (
  input logic                  clk,
  input logic                  rst,
  decoder_iter_ctrl_if.master  bus
);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(N_ITER);

  state_t           state;
  logic             wd_expired;
  logic [TMO_W-1:0] unused_wd_count;

  decoder_watchdog #(
    .TMO_W   (TMO_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == START),
    .enable  (state == WAIT),
    .count   (unused_wd_count),
    .expired (wd_expired)
  );

  // Outputs are computed for the state being entered, so each one is valid
  // in the same cycle as the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bus.llr_ack     <= RESET_VAL;
      bus.load_en     <= RESET_VAL;
      bus.layer_start <= RESET_VAL;
      bus.out_valid   <= RESET_VAL;
      bus.iters_used  <= '0;
      bus.early_stop  <= RESET_VAL;
      bus.timeout_err <= RESET_VAL;
      bus.busy        <= RESET_VAL;
    end else begin
      bus.llr_ack     <= 1'b0;
      bus.load_en     <= 1'b0;
      bus.layer_start <= 1'b0;
      case (state)
        IDLE: if (bus.llr_ready) begin
          state           <= LOAD;
          bus.llr_ack     <= 1'b1;
          bus.load_en     <= 1'b1;
          bus.iters_used  <= '0;
          bus.early_stop  <= 1'b0;
          bus.timeout_err <= 1'b0;
          bus.busy        <= 1'b1;
        end
        LOAD: begin
          state           <= START;
          bus.layer_start <= 1'b1;
        end
        START: state <= WAIT;
        WAIT: begin
          // A completion in the expiry cycle still counts as a finished layer.
          if (bus.layer_done) begin
            state          <= CHECK;
            bus.iters_used <= bus.iters_used + 1'b1;
          end else if (wd_expired) begin
            state           <= DONE;
            bus.timeout_err <= 1'b1;
            bus.out_valid   <= 1'b1;
          end
        end
        CHECK: begin
          if (bus.syndrome_ok) begin
            state          <= DONE;
            bus.early_stop <= 1'b1;
            bus.out_valid  <= 1'b1;
          end else if (bus.iters_used == ITER_MAX) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
          end else begin
            state           <= START;
            bus.layer_start <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
